// File: rtl/fb_port_arbiter_if.sv
// Frame buffer port bundle: two requesters (draw engine r0, readout engine r1)
// on one side and the single-port frame buffer macro on the other.
// The arbiter connects through the slave modport; requesters and the memory
// model connect through the master modport.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    // draw engine (read/write)
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r0_gnt;
    logic              r0_rvalid;

    // readout engine (read only)
    logic              r1_req;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_gnt;
    logic              r1_rvalid;

    // shared read data
    logic [DATA_W-1:0] rd_rdata;

    // frame buffer macro pins
    logic              FB_CEN;
    logic              FB_WEN;
    logic [ADDR_W-1:0] FB_A;
    logic [DATA_W-1:0] FB_D;
    logic [DATA_W-1:0] FB_Q;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_data,
        input  r1_req, r1_addr,
        input  FB_Q,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rd_rdata,
        output FB_CEN, FB_WEN, FB_A, FB_D
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_data,
        output r1_req, r1_addr,
        output FB_Q,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rd_rdata,
        input  FB_CEN, FB_WEN, FB_A, FB_D
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame buffer between the draw
// engine (r0, read/write) and the readout engine (r1, read only) with a
// two-way round-robin, plus an optional clear sequencer that fills the
// whole buffer with bg_color.
//
// Build option: define FB_CLEAR_EN to compile in the clear sequencer.
// Without it, clear_start/bg_color are ignored and clear_busy/clear_done
// are tied low; arbitration is unchanged.
//
// Grants and FB_* are combinational so the memory samples them at the next
// rising edge; read-valid flags are registered to line up with the one-cycle
// registered FB_Q.
module fb_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bg_color,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    fb_port_arbiter_if.slave  bus
);

    // round-robin state: 1 means r1 won the last grant, so r0 wins next tie
    logic last_r1_q;
    logic last_r1_d;

    // read-valid flags, one cycle after a read grant
    logic r0_rvalid_q;
    logic r0_rvalid_d;
    logic r1_rvalid_q;
    logic r1_rvalid_d;

    // port ownership and clear-write view shared by both build variants
    logic              port_free_s;
    logic              clr_wr_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic [DATA_W-1:0] clr_data_s;

    logic              r0_gnt_s;
    logic              r1_gnt_s;
    logic              fb_cen_s;
    logic              fb_wen_s;
    logic [ADDR_W-1:0] fb_a_s;
    logic [DATA_W-1:0] fb_d_s;

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    // clear sequencer next state: one write per cycle, wrap and stop after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // clear sequencer registers; busy/done are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // a clear request in IDLE takes the port this very cycle, so no grant is issued
    assign port_free_s = (state_q == ST_IDLE) && !clear_start;
    assign clr_wr_s    = (state_q == ST_CLEAR);
    assign clr_addr_s  = cnt_q;
    assign clr_data_s  = bg_color;
    assign clear_busy  = busy_q;
    assign clear_done  = done_q;
`else
    logic unused_clear_s;

    assign port_free_s    = 1'b1;
    assign clr_wr_s       = 1'b0;
    assign clr_addr_s     = {ADDR_W{1'b0}};
    assign clr_data_s     = {DATA_W{1'b0}};
    assign clear_busy     = 1'b0;
    assign clear_done     = 1'b0;
    assign unused_clear_s = ^{clear_start, bg_color};
`endif

    // round-robin grant: lone requester wins, on a tie the loser of the last grant wins
    always_comb begin
        r0_gnt_s = 1'b0;
        r1_gnt_s = 1'b0;
        if (!reset && port_free_s) begin
            if (bus.r0_req && (!bus.r1_req || last_r1_q)) begin
                r0_gnt_s = 1'b1;
            end else if (bus.r1_req) begin
                r1_gnt_s = 1'b1;
            end else begin
                r0_gnt_s = 1'b0;
                r1_gnt_s = 1'b0;
            end
        end else begin
            r0_gnt_s = 1'b0;
            r1_gnt_s = 1'b0;
        end
    end

    // frame buffer pin mux; an idle port parks at address/data zero
    always_comb begin
        fb_cen_s = 1'b1;
        fb_wen_s = 1'b1;
        fb_a_s   = {ADDR_W{1'b0}};
        fb_d_s   = {DATA_W{1'b0}};
        if (r0_gnt_s) begin
            fb_cen_s = 1'b0;
            fb_wen_s = !bus.r0_we;
            fb_a_s   = bus.r0_addr;
            fb_d_s   = bus.r0_data;
        end else if (r1_gnt_s) begin
            fb_cen_s = 1'b0;
            fb_wen_s = 1'b1;
            fb_a_s   = bus.r1_addr;
            fb_d_s   = {DATA_W{1'b0}};
        end else if (!reset && clr_wr_s) begin
            fb_cen_s = 1'b0;
            fb_wen_s = 1'b0;
            fb_a_s   = clr_addr_s;
            fb_d_s   = clr_data_s;
        end else begin
            fb_cen_s = 1'b1;
            fb_wen_s = 1'b1;
            fb_a_s   = {ADDR_W{1'b0}};
            fb_d_s   = {DATA_W{1'b0}};
        end
    end

    // next values for the last-winner flag and the read-valid flags
    always_comb begin
        last_r1_d   = last_r1_q;
        r0_rvalid_d = r0_gnt_s && !bus.r0_we;
        r1_rvalid_d = r1_gnt_s;
        if (r0_gnt_s) begin
            last_r1_d = 1'b0;
        end else if (r1_gnt_s) begin
            last_r1_d = 1'b1;
        end else begin
            last_r1_d = last_r1_q;
        end
    end

    // arbitration registers; r1 counts as last winner out of reset so r0 wins first
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r1_q   <= 1'b1;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            last_r1_q   <= last_r1_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
        end
    end

    assign bus.r0_gnt    = r0_gnt_s;
    assign bus.r1_gnt    = r1_gnt_s;
    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    assign bus.rd_rdata  = bus.FB_Q;
    assign bus.FB_CEN    = fb_cen_s;
    assign bus.FB_WEN    = fb_wen_s;
    assign bus.FB_A      = fb_a_s;
    assign bus.FB_D      = fb_d_s;

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: frame buffer address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 12: pixel width (RGB 4:4:4).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bg_color  input  DATA_W  background fill value for the clear sequencer.
REQ-006 clear_start  input  1  one-cycle request to fill the whole buffer with bg_color.
REQ-007 clear_busy  output  1  high while the clear sequencer owns the port.
REQ-008 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-009 r0_req, r0_we, r0_addr, r0_data  input  1/1/ADDR_W/DATA_W  draw-engine access request; r0_we=1 write, r0_we=0 read.
REQ-010 r0_gnt  output  1  draw access accepted this cycle.
REQ-011 r1_req, r1_addr  input  1/ADDR_W  readout-engine read request.
REQ-012 r1_gnt  output  1  readout access accepted this cycle.
REQ-013 rd_rdata  output  DATA_W  read data, equal to FB_Q.
REQ-014 r0_rvalid, r1_rvalid  output  1  rd_rdata is valid for that requester this cycle.
REQ-015 FB_CEN, FB_WEN  output  1  frame buffer chip and write enables, both active-low.
REQ-016 FB_A, FB_D  output  ADDR_W/DATA_W  frame buffer address and write data.
REQ-017 FB_Q  input  DATA_W  frame buffer registered read data, valid one cycle after a read access.

Function
REQ-018 Grants and FB_* outputs shall be combinational from the current requests and state; the memory samples them at the next rising edge.
REQ-019 At most one of r0_gnt and r1_gnt shall be high in any cycle.
REQ-020 No access in a cycle: FB_CEN=1, FB_WEN=1, FB_A=0, FB_D=0.
REQ-021 Granted r0: FB_CEN=0, FB_WEN=~r0_we, FB_A=r0_addr, FB_D=r0_data.
REQ-022 Granted r1: FB_CEN=0, FB_WEN=1, FB_A=r1_addr, FB_D=0.
REQ-023 Arbitration shall be round-robin using a last-winner flag. When only one requester is active, that requester is granted. When both are active, the requester that did not win last is granted. The flag updates only on a grant.
REQ-024 r0_rvalid and r1_rvalid are registered: rXrvalid=1 exactly in the cycle after a read grant to rX.
REQ-025 Requesters hold their request, address and data until granted; an ungranted request has no side effect.
REQ-026 The clear FSM has three states: IDLE, CLEAR and DONE.
  - IDLE->CLEAR on clear_start=1; the address counter is set to 0.
  - CLEAR: FB_CEN=0, FB_WEN=0, FB_A=counter, FB_D=bg_color; the counter increments each cycle.
  - CLEAR->DONE when the counter equals 2^ADDR_W-1, after that write. The counter wraps to 0 and does not advance further.
  - DONE->IDLE unconditionally; clear_done=1 during DONE only.
REQ-027 clear_busy=1 in CLEAR and DONE. While busy, r0_gnt=r1_gnt=0; in DONE the port is idle.
REQ-028 A clear takes exactly 2^ADDR_W write cycles plus 1 DONE cycle: 4097 cycles at the default width.
REQ-029 clear_start while busy shall be ignored.
REQ-030 clear_start and requests in the same IDLE cycle: the clear wins, and no grant is issued that cycle.
REQ-031 A read granted in the cycle before CLEAR is entered still returns rXrvalid in the first CLEAR cycle.

Reset
REQ-032 Reset values:
  - FSM=IDLE, counter=0, clear_busy=0, clear_done=0.
  - r0_rvalid=r1_rvalid=0.
  - Last-winner flag=r1, so r0 wins the first contention.
  - FB_CEN=FB_WEN=1.
REQ-033 Reset asserted mid-clear shall abort the clear at the next edge without a clear_done pulse; buffer contents are unspecified.
REQ-034 Grants shall be 0 while reset=1.

Configuration
REQ-035 Macro FB_CLEAR_EN defined: the clear sequencer per REQ-026..031 is compiled in.
REQ-036 FB_CLEAR_EN undefined:
  - No FSM or counter.
  - clear_start and bg_color are ignored.
  - clear_busy=clear_done=0.
  - Ports are unchanged and arbitration is identical.

Verification
REQ-037 After reset, r0_req=1 with r0_we=1, addr=0x040, data=0xB97, and r1_req=1 with addr=0x041, both held. Required: r0_gnt=1, FB_CEN=0, FB_WEN=0, FB_A=0x040, FB_D=0xB97; next cycle r1_gnt=1, FB_A=0x041.
REQ-038 Both requesters held for 6 cycles. Required: grants alternate r0,r1,r0,r1,r0,r1, with r1_rvalid=1 the cycle after each r1 grant and rd_rdata=FB_Q.
REQ-039 clear_start pulse with bg_color=0xB97, r0/r1 requesting throughout. Required:
  - no grants for 4097 cycles;
  - writes to 0x000..0xFFF in order;
  - clear_done=1 in cycle 4097;
  - readback of all 4096 words = 0xB97.
REQ-040 clear_start re-pulsed at counter=0x100. Required: sequence unaffected, single clear_done.
REQ-041 reset at counter=0x800. Required: FB_CEN=1 next cycle, clear_busy=0, no clear_done pulse, r0 wins the next contention.
REQ-042 Build without FB_CLEAR_EN and pulse clear_start. Required: clear_busy stays 0, and r0/r1 grants continue per REQ-023.
